// File: rtl/reg_wb.sv
// Writeback stage: registers ALU results, waits for load data and extends it, and counts retired writes.
// Optional `WB_FWD_EN adds a combinational bypass of the write scheduled for the next cycle.
module reg_wb (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rd,
    input  logic        in_wen,
    input  logic        in_is_load,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_alu_result,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic [4:0]  reg_waddr_o,
    output logic [31:0] reg_wdata_o,
    output logic        reg_wen_o,
    output logic        busy_o,
    output logic [31:0] retire_cnt_o
`ifdef WB_FWD_EN
    ,
    output logic        fwd_valid_o,
    output logic [4:0]  fwd_addr_o,
    output logic [31:0] fwd_data_o
`endif
);

    typedef enum logic {IDLE = 1'b0, WAIT_LOAD = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [4:0]  ld_rd;
    logic        ld_wen;
    logic [2:0]  ld_f3;
    logic [1:0]  ld_off;
    logic        ld_cap;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] shifted;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_ext;

    assign in_ready = rst && (state_q == IDLE);
    assign busy_o   = (state_q == WAIT_LOAD);

    // Memory returns the aligned word; pick the lane using the captured address offset.
    assign shifted = dmem_rdata >> {ld_off, 3'b000};
    assign ld_byte = shifted[7:0];
    assign ld_half = ld_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        case (ld_f3)
            3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_ext = {24'b0, ld_byte};
            3'b101:  load_ext = {16'b0, ld_half};
            default: load_ext = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        wr_addr = in_rd;
        wr_data = in_alu_result;
        ld_cap  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    if (in_is_load) begin
                        state_d = WAIT_LOAD;
                        ld_cap  = 1'b1;
                    end else begin
                        wr_en = in_wen && (in_rd != 5'd0);
                    end
                end
            end
            WAIT_LOAD: begin
                if (dmem_rvalid) begin
                    state_d = IDLE;
                    wr_en   = ld_wen && (ld_rd != 5'd0);
                    wr_addr = ld_rd;
                    wr_data = load_ext;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Suppressed writes leave address/data holding the last committed write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            reg_wen_o    <= 1'b0;
            reg_waddr_o  <= 5'd0;
            reg_wdata_o  <= 32'd0;
            retire_cnt_o <= 32'd0;
            ld_rd        <= 5'd0;
            ld_wen       <= 1'b0;
            ld_f3        <= 3'd0;
            ld_off       <= 2'd0;
        end else begin
            reg_wen_o    <= wr_en;
            retire_cnt_o <= retire_cnt_o + {31'd0, reg_wen_o};
            if (wr_en) begin
                reg_waddr_o <= wr_addr;
                reg_wdata_o <= wr_data;
            end
            if (ld_cap) begin
                ld_rd  <= in_rd;
                ld_wen <= in_wen;
                ld_f3  <= in_funct3;
                ld_off <= in_alu_result[1:0];
            end
        end
    end

`ifdef WB_FWD_EN
    assign fwd_valid_o = wr_en;
    assign fwd_addr_o  = wr_addr;
    assign fwd_data_o  = wr_data;
`endif

endmodule

// File: tb/tb_reg_wb.sv
// Bench for reg_wb: per-cycle comparison against a behavioural writeback model plus directed literal checks.
module tb_reg_wb;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_wen, in_is_load, dmem_rvalid;
    logic        in_ready, reg_wen_o, busy_o;
    logic [4:0]  in_rd, reg_waddr_o;
    logic [2:0]  in_funct3;
    logic [31:0] in_alu_result, dmem_rdata, reg_wdata_o, retire_cnt_o;
`ifdef WB_FWD_EN
    logic        fwd_valid_o;
    logic [4:0]  fwd_addr_o;
    logic [31:0] fwd_data_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_wb dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_wen(in_wen), .in_is_load(in_is_load), .in_funct3(in_funct3),
        .in_alu_result(in_alu_result), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o), .reg_wen_o(reg_wen_o),
        .busy_o(busy_o), .retire_cnt_o(retire_cnt_o)
`ifdef WB_FWD_EN
        , .fwd_valid_o(fwd_valid_o), .fwd_addr_o(fwd_addr_o), .fwd_data_o(fwd_data_o)
`endif
    );

    // Behavioural model: a pending-load record and the last committed write.
    logic        m_pend;
    logic [4:0]  m_prd;
    logic        m_pwen;
    logic [2:0]  m_pf3;
    logic [1:0]  m_poff;
    logic        m_wen;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic [31:0] m_cnt;
    bit          m_live = 0;

    function automatic logic [31:0] ext(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] d);
        longint unsigned b, h;
        b = (longint'(d) >> (8 * off)) % 256;
        h = (off >= 2) ? (longint'(d) / 65536) : (longint'(d) % 65536);
        case (f3)
            3'd0:    return (b >= 128) ? 32'(b + 64'hFFFFFF00) : 32'(b);
            3'd1:    return (h >= 32768) ? 32'(h + 64'hFFFF0000) : 32'(h);
            3'd4:    return 32'(b);
            3'd5:    return 32'(h);
            default: return d;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_pend = 0; m_wen = 0; m_waddr = 0; m_wdata = 0; m_cnt = 0;
            m_prd = 0; m_pwen = 0; m_pf3 = 0; m_poff = 0;
            m_live = 1;
        end else if (m_live) begin
            m_cnt = m_cnt + (m_wen ? 32'd1 : 32'd0);
            m_wen = 0;
            if (!m_pend && in_valid) begin
                if (in_is_load) begin
                    m_pend = 1; m_prd = in_rd; m_pwen = in_wen;
                    m_pf3 = in_funct3; m_poff = in_alu_result[1:0];
                end else if (in_wen && in_rd != 0) begin
                    m_wen = 1; m_waddr = in_rd; m_wdata = in_alu_result;
                end
            end else if (m_pend && dmem_rvalid) begin
                m_pend = 0;
                if (m_pwen && m_prd != 0) begin
                    m_wen = 1; m_waddr = m_prd; m_wdata = ext(m_pf3, m_poff, dmem_rdata);
                end
            end
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_live) begin
            cmp("wen",      32'(reg_wen_o),  32'(m_wen));
            cmp("waddr",    32'(reg_waddr_o), 32'(m_waddr));
            cmp("wdata",    reg_wdata_o,     m_wdata);
            cmp("busy",     32'(busy_o),     32'(m_pend));
            cmp("retire",   retire_cnt_o,    m_cnt);
            cmp("in_ready", 32'(in_ready),   32'(rst && !m_pend));
        end
    end

    task automatic tick(); @(posedge clk); #1; endtask

    task automatic idle();
        in_valid = 0; in_wen = 0; in_is_load = 0; in_rd = 0; in_funct3 = 0;
        in_alu_result = 0; dmem_rvalid = 0; dmem_rdata = 0;
    endtask

    task automatic alu(input logic [4:0] rd, input logic wen, input logic [31:0] v);
        in_valid = 1; in_is_load = 0; in_rd = rd; in_wen = wen; in_alu_result = v; in_funct3 = 0;
    endtask

    task automatic ld(input logic [4:0] rd, input logic wen, input logic [2:0] f3, input logic [31:0] a);
        in_valid = 1; in_is_load = 1; in_rd = rd; in_wen = wen; in_funct3 = f3; in_alu_result = a;
    endtask

    // Load issued, one empty wait cycle, then the response.
    task automatic load_seq(input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] data);
        ld(rd, 1, f3, a); tick();
        idle(); tick();
        dmem_rvalid = 1; dmem_rdata = data; tick();
        idle();
    endtask

    initial begin
        idle();
        rst = 0;
        tick(); tick();
        cmp("rst_ready", 32'(in_ready), 32'd0);
        cmp("rst_cnt", retire_cnt_o, 32'd0);
        rst = 1;

        alu(5, 1, 32'h12345678);
`ifdef WB_FWD_EN
        #1;
        cmp("fwd_valid5", 32'(fwd_valid_o), 32'd1);
        cmp("fwd_data5", fwd_data_o, 32'h12345678);
`endif
        tick(); idle();
        cmp("add_wen", 32'(reg_wen_o), 32'd1);
        cmp("add_waddr", 32'(reg_waddr_o), 32'd5);
        cmp("add_wdata", reg_wdata_o, 32'h12345678);
        tick();
        cmp("add_cnt", retire_cnt_o, 32'd1);

        // LB byte 2, sign-extended
        ld(7, 1, 3'b000, 32'h0000_1002); tick(); idle();
        cmp("lb_busy", 32'(busy_o), 32'd1);
        cmp("lb_ready", 32'(in_ready), 32'd0);
        tick();
        dmem_rvalid = 1; dmem_rdata = 32'h0080_0000; tick(); idle();
        cmp("lb_wdata", reg_wdata_o, 32'hFFFFFF80);
        cmp("lb_waddr", 32'(reg_waddr_o), 32'd7);
        cmp("lb_busy_end", 32'(busy_o), 32'd0);

        load_seq(3, 3'b101, 32'h2002, 32'hBEEF1234);
        cmp("lhu_wdata", reg_wdata_o, 32'h0000BEEF);
        load_seq(3, 3'b001, 32'h2002, 32'hBEEF1234);
        cmp("lh_wdata", reg_wdata_o, 32'hFFFFBEEF);
        load_seq(4, 3'b100, 32'h2003, 32'h9A345678);
        cmp("lbu_wdata", reg_wdata_o, 32'h0000009A);
        load_seq(6, 3'b010, 32'h2000, 32'hCAFEF00D);
        cmp("lw_wdata", reg_wdata_o, 32'hCAFEF00D);
        load_seq(8, 3'b011, 32'h2001, 32'h8765_4321);
        cmp("f3_11_wdata", reg_wdata_o, 32'h87654321);
        load_seq(1, 3'b000, 32'h2001, 32'h0000_7F00);
        cmp("lb1_wdata", reg_wdata_o, 32'h0000007F);

        // rd=0 and wen=0 suppress the write and hold addr/data
        tick();
        alu(0, 1, 32'hFFFFFFFF); tick();
        alu(9, 0, 32'h0BAD0BAD); tick(); idle();
        cmp("rd0_wen", 32'(reg_wen_o), 32'd0);
        cmp("rd0_wdata", reg_wdata_o, 32'h0000007F);
        dmem_rvalid = 1; dmem_rdata = 32'h1111_1111; tick(); idle(); tick();
        cmp("idle_rvalid_wen", 32'(reg_wen_o), 32'd0);
        cmp("cnt_after8", retire_cnt_o, 32'd8);

        // Back-to-back ALU writes
        alu(10, 1, 32'hA); tick();
        alu(11, 1, 32'hB); tick();
        cmp("b2b_addr", 32'(reg_waddr_o), 32'd11);
        alu(12, 1, 32'hC); tick(); idle(); tick();
        cmp("b2b_cnt", retire_cnt_o, 32'd11);

        // ALU op held during WAIT_LOAD is taken only after the load completes
        ld(13, 1, 3'b010, 32'h40); tick();
        alu(14, 1, 32'h77); tick(); tick();
        dmem_rvalid = 1; dmem_rdata = 32'h5555_AAAA; tick();
        dmem_rvalid = 0;
        cmp("held_ld_data", reg_wdata_o, 32'h5555AAAA);
        tick(); idle();
        cmp("held_alu_addr", 32'(reg_waddr_o), 32'd14);
        cmp("held_alu_data", reg_wdata_o, 32'h77);
        tick();

        // Reset during WAIT_LOAD drops the pending load
        ld(15, 1, 3'b010, 32'h80); tick(); idle();
        rst = 0; tick(); rst = 1;
        dmem_rvalid = 1; dmem_rdata = 32'h1; tick(); idle(); tick();
        cmp("rstwait_wen", 32'(reg_wen_o), 32'd0);
        cmp("rstwait_busy", 32'(busy_o), 32'd0);
        cmp("rstwait_cnt", retire_cnt_o, 32'd0);
        cmp("rstwait_ready", 32'(in_ready), 32'd1);

`ifdef WB_FWD_EN
        alu(9, 1, 32'h55); #1;
        cmp("fwd_valid", 32'(fwd_valid_o), 32'd1);
        cmp("fwd_addr", 32'(fwd_addr_o), 32'd9);
        cmp("fwd_data", fwd_data_o, 32'h55);
        alu(0, 1, 32'h55); #1;
        cmp("fwd_rd0", 32'(fwd_valid_o), 32'd0);
        tick(); idle(); tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_wb.md
REG_WB -- requirements
Module: reg_wb

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port in_valid  input  1  MEM stage presents a retiring instruction.
REQ-004 SHALL have port in_ready  output  1  block accepts in_valid this cycle.
REQ-005 SHALL have port in_rd  input  5  destination register index.
REQ-006 SHALL have port in_wen  input  1  instruction writes rd.
REQ-007 SHALL have port in_is_load  input  1  result comes from data memory.
REQ-008 SHALL have port in_funct3  input  3  load width/sign code.
REQ-009 SHALL have port in_alu_result  input  32  ALU result, or load address for loads.
REQ-010 SHALL have port dmem_rvalid  input  1  load data response valid.
REQ-011 SHALL have port dmem_rdata  input  32  aligned 32-bit word from data memory.
REQ-012 SHALL have port reg_waddr_o  output  5  register-file write index.
REQ-013 SHALL have port reg_wdata_o  output  32  register-file write data.
REQ-014 SHALL have port reg_wen_o  output  1  register-file write strobe, one cycle per write.
REQ-015 SHALL have port busy_o  output  1  load outstanding.
REQ-016 SHALL have port retire_cnt_o  output  32  count of committed register writes.

Function
REQ-017 SHALL implement states IDLE, WAIT_LOAD; reg_waddr_o/reg_wdata_o/reg_wen_o SHALL be registered.
REQ-018 in_ready SHALL be 1 in IDLE, 0 in WAIT_LOAD; acceptance = in_valid & in_ready.
REQ-019 Non-load accepted in cycle N: reg_wen_o=1 in cycle N+1 only, reg_wdata_o=in_alu_result, reg_waddr_o=in_rd; back-to-back acceptances SHALL give back-to-back writes.
REQ-020 Load accepted: capture rd, wen, funct3, in_alu_result[1:0]; enter WAIT_LOAD; busy_o=1.
REQ-021 In WAIT_LOAD with dmem_rvalid=1 in cycle M: return to IDLE; reg_wen_o=1 in cycle M+1 with extended data.
REQ-022 Extension: 000 LB sign-ext byte at addr[1:0]; 001 LH sign-ext half at addr[1]; 010 LW word; 100 LBU zero-ext byte; 101 LHU zero-ext half; other codes SHALL be treated as LW.
REQ-023 Writes with rd=0 or in_wen=0 SHALL keep reg_wen_o=0, and reg_waddr_o/reg_wdata_o SHALL retain their previous values.
REQ-024 dmem_rvalid in IDLE SHALL be ignored.
REQ-025 retire_cnt_o SHALL increment by 1 each cycle reg_wen_o=1, wrapping 0xFFFFFFFF -> 0.
REQ-026 in_valid while in_ready=0 SHALL not be captured; upstream holds it.

Reset
REQ-027 rst=0 at a clock edge SHALL force IDLE, reg_wen_o=0, reg_waddr_o=0, reg_wdata_o=0, busy_o=0, retire_cnt_o=0.
REQ-028 Reset during WAIT_LOAD SHALL discard the pending load; a later dmem_rvalid SHALL produce no write.
REQ-029 During reset in_ready SHALL be 0.

Configuration
REQ-030 Macro WB_FWD_EN defined: ports fwd_valid_o (1), fwd_addr_o (5), fwd_data_o (32) SHALL exist, combinationally equal to the write scheduled for the next cycle (non-load accept, or WAIT_LOAD with dmem_rvalid=1), fwd_valid_o=0 for rd=0 or in_wen=0.
REQ-031 Macro WB_FWD_EN undefined: those ports and their logic SHALL be absent; all other behaviour identical.

Verification
REQ-032 Reset then ADD rd=5, alu=0x12345678 accepted cycle 3 -> cycle 4 reg_wen_o=1, waddr=5, wdata=0x12345678, retire_cnt_o=1 in cycle 5.
REQ-033 LB rd=7, addr[1:0]=2, rvalid two cycles later with rdata=0x00800000 -> in_ready=0 and busy_o=1 while waiting, then wdata=0xFFFFFF80.
REQ-034 LHU rd=3, addr[1]=1, rdata=0xBEEF1234 -> wdata=0x0000BEEF; LH same -> 0xFFFFBEEF.
REQ-035 ALU op rd=0, alu=0xFFFFFFFF -> reg_wen_o stays 0, retire_cnt_o unchanged; dmem_rvalid pulse in IDLE -> no write.
REQ-036 Load accepted, rst=0 for one cycle before rvalid, then rvalid with rdata=0x1 -> no write, state IDLE, retire_cnt_o=0.
REQ-037 With WB_FWD_EN: ADD rd=9 alu=0x55 accepted -> same cycle fwd_valid_o=1, fwd_addr_o=9, fwd_data_o=0x55.
